// File: rtl/lsu_rmw_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes and the
// access-legality check applied when a request is accepted.
package lsu_rmw_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants exist only for loads; stores accept B/H/W only.
    function automatic logic access_illegal(input logic       store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic illegal_s;
        case (funct3)
            F3_B:         illegal_s = 1'b0;
            F3_H:         illegal_s = addr_lo[0];
            F3_W:         illegal_s = (addr_lo != 2'b00);
            F3_BU, F3_HU: illegal_s = store;
            default:      illegal_s = 1'b1;
        endcase
        return illegal_s;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// merges a byte or halfword store into a previously read word (little-endian).
module lsu_align
    import lsu_rmw_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merge_data
);

    logic [XLEN-1:0] shifted_s;
    logic [7:0]      byte_s;
    logic [15:0]     half_s;

    // Load extraction: select the addressed lane, then sign- or zero-extend.
    always_comb begin
        shifted_s = word >> {addr_lo, 3'b000};
        byte_s    = shifted_s[7:0];
        half_s    = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   load_data = {24'h000000, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_HU:   load_data = {16'h0000, half_s};
            F3_W:    load_data = word;
            default: load_data = {XLEN{1'b0}};
        endcase
    end

    // Store merge: replace only the addressed lane of the old word.
    always_comb begin
        merge_data = old;
        case (funct3)
            F3_B: begin
                case (addr_lo)
                    2'd0:    merge_data[7:0]   = wdata[7:0];
                    2'd1:    merge_data[15:8]  = wdata[7:0];
                    2'd2:    merge_data[23:16] = wdata[7:0];
                    2'd3:    merge_data[31:24] = wdata[7:0];
                    default: merge_data        = old;
                endcase
            end
            F3_H: begin
                if (addr_lo[1]) begin
                    merge_data[31:16] = wdata[15:0];
                end else begin
                    merge_data[15:0] = wdata[15:0];
                end
            end
            F3_W:    merge_data = wdata;
            default: merge_data = old;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit between the MEM stage and a word-only data memory. Byte and
// halfword stores are done as read-modify-write since the memory has no byte enables.
module lsu_rmw
    import lsu_rmw_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              dmem_memRead,
    output logic              dmem_memWrite,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state_r;
    logic              store_r;
    logic [2:0]        funct3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [XLEN-1:0]   wdata_r;
    logic [XLEN-1:0]   merge_r;
    logic [XLEN-1:0]   rdata_r;
    logic              err_r;
    logic [XLEN-1:0]   load_data_s;
    logic [XLEN-1:0]   merge_data_s;
    logic [ADDR_W-1:0] word_addr_s;

    assign word_addr_s = {addr_r[ADDR_W-1:2], 2'b00};

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (funct3_r),
        .addr_lo    (addr_r[1:0]),
        .word       (dmem_rdata),
        .old        (merge_r),
        .wdata      (wdata_r),
        .load_data  (load_data_s),
        .merge_data (merge_data_s)
    );

    // Request FSM with request latches, merge buffer and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            store_r  <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= {XLEN{1'b0}};
            merge_r  <= {XLEN{1'b0}};
            rdata_r  <= {XLEN{1'b0}};
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        store_r  <= req_store;
                        funct3_r <= req_funct3;
                        addr_r   <= req_addr;
                        wdata_r  <= req_wdata;
                        rdata_r  <= {XLEN{1'b0}};
                        err_r    <= access_illegal(req_store, req_funct3, req_addr[1:0]);
                        state_r  <= access_illegal(req_store, req_funct3, req_addr[1:0])
                                    ? ST_RESP : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!store_r) begin
                        rdata_r <= load_data_s;
                        state_r <= ST_RESP;
                    end else if (funct3_r == F3_W) begin
                        state_r <= ST_RESP;
                    end else begin
                        merge_r <= dmem_rdata;
                        state_r <= ST_WRITE;
                    end
                end
                ST_WRITE: state_r <= ST_RESP;
                ST_RESP:  state_r <= ST_IDLE;
                default:  state_r <= ST_IDLE;
            endcase
        end
    end

    // Output decode from registered state; rst_n gates everything so a
    // reset edge can never carry a memory write.
    always_comb begin
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = {XLEN{1'b0}};
        resp_err      = 1'b0;
        dmem_memRead  = 1'b0;
        dmem_memWrite = 1'b0;
        dmem_addr     = {ADDR_W{1'b0}};
        dmem_wdata    = {XLEN{1'b0}};
        if (rst_n) begin
            resp_rdata = rdata_r;
            resp_err   = err_r;
            case (state_r)
                ST_IDLE: req_ready = 1'b1;
                ST_ACCESS: begin
                    dmem_addr = word_addr_s;
                    if (store_r && (funct3_r == F3_W)) begin
                        dmem_memWrite = 1'b1;
                        dmem_wdata    = wdata_r;
                    end else begin
                        dmem_memRead = 1'b1;
                    end
                end
                ST_WRITE: begin
                    dmem_memWrite = 1'b1;
                    dmem_addr     = word_addr_s;
                    dmem_wdata    = merge_data_s;
                end
                ST_RESP: resp_valid = 1'b1;
                default: req_ready = 1'b0;
            endcase
        end else begin
            req_ready     = 1'b0;
            dmem_memWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw with a word-only DMem model downstream and a
// scoreboard of expected responses.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dmem_memRead;
    logic        dmem_memWrite;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;

    logic [31:0] mem [0:63] = '{default: 32'h0};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   acc_q[$];
    int   tests = 0;
    int   fails = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    lsu_rmw dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .dmem_memRead  (dmem_memRead),
        .dmem_memWrite (dmem_memWrite),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata)
    );

    assign dmem_rdata = mem[dmem_addr[7:2]];

    always @(posedge clk) begin
        if (dmem_memWrite) mem[dmem_addr[7:2]] <= dmem_wdata;
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dmem_memRead)  rd_cnt <= rd_cnt + 1;
        if (dmem_memWrite) wr_cnt <= wr_cnt + 1;
    end

    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) acc_q.push_back(cyc);
    end

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] er, input logic ee,
                          input int el);
        exp_t e;
        int   lat;
        bit   got;
        sb_q.push_back('{er, ee, el});
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 1'b0; lat = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin got = 1'b1; lat = i; end
        end
        e = sb_q.pop_front();
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL resp_timeout addr=%h: no resp_valid within 10 cycles", a);
        end else begin
            tests += 3;
            if (resp_rdata !== e.rdata) begin
                fails++; $display("FAIL rdata addr=%h: got %h expected %h", a, resp_rdata, e.rdata);
            end
            if (resp_err !== e.err) begin
                fails++; $display("FAIL err addr=%h: got %b expected %b", a, resp_err, e.err);
            end
            if (lat !== e.lat) begin
                fails++; $display("FAIL latency addr=%h: got %0d expected %0d", a, lat, e.lat);
            end
            @(negedge clk);
            tests++;
            if (resp_valid !== 1'b0 || resp_rdata !== e.rdata) begin
                fails++; $display("FAIL resp_hold addr=%h: valid=%b rdata=%h expected 0/%h",
                                  a, resp_valid, resp_rdata, e.rdata);
            end
        end
    endtask

    task automatic check_word(input string name, input int idx, input logic [31:0] exp);
        tests++;
        if (mem[idx] !== exp) begin
            fails++; $display("FAIL %s: mem[%0d]=%h expected %h", name, idx, mem[idx], exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        tests++;
        if ({req_ready, resp_valid, resp_rdata, resp_err, dmem_memRead, dmem_memWrite,
             dmem_addr, dmem_wdata} !== 100'h0) begin
            fails++; $display("FAIL reset_outputs: some output nonzero during reset (ready=%b)", req_ready);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_word();
        int w0;
        w0 = wr_cnt;
        do_req(1'b1, 3'b010, 32'h0, 32'hAAAABBBB, 32'h0, 1'b0, 2);
        tests++;
        if (wr_cnt - w0 !== 1) begin
            fails++; $display("FAIL sw_write_pulses: got %0d expected 1", wr_cnt - w0);
        end
        check_word("sw_mem0", 0, 32'hAAAABBBB);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'hAAAABBBB, 1'b0, 2);
    endtask

    task automatic test_load_extend();
        do_req(1'b1, 3'b010, 32'h4, 32'hCCCCDDDD, 32'h0, 1'b0, 2);
        do_req(1'b0, 3'b000, 32'h5, 32'h0, 32'hFFFFFFDD, 1'b0, 2);
        do_req(1'b0, 3'b100, 32'h7, 32'h0, 32'h000000CC, 1'b0, 2);
        do_req(1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFFCCCC, 1'b0, 2);
        do_req(1'b0, 3'b101, 32'h4, 32'h0, 32'h0000DDDD, 1'b0, 2);
        do_req(1'b0, 3'b000, 32'h4, 32'h0, 32'hFFFFFFDD, 1'b0, 2);
    endtask

    task automatic test_rmw();
        do_req(1'b1, 3'b010, 32'h8, 32'h00000007, 32'h0, 1'b0, 2);
        do_req(1'b1, 3'b000, 32'h9, 32'h12345678, 32'h0, 1'b0, 3);
        check_word("sb_merge", 2, 32'h00007807);
        do_req(1'b1, 3'b001, 32'hA, 32'h0000BEEF, 32'h0, 1'b0, 3);
        check_word("sh_merge", 2, 32'hBEEF7807);
    endtask

    task automatic test_illegal();
        int r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b1, 1);
        do_req(1'b1, 3'b001, 32'h3, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        do_req(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1);
        do_req(1'b1, 3'b100, 32'h8, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        tests++;
        if (rd_cnt != r0 || wr_cnt != w0) begin
            fails++; $display("FAIL illegal_strobes: reads=%0d writes=%0d expected 0/0", rd_cnt - r0, wr_cnt - w0);
        end
        check_word("illegal_mem0", 0, 32'hAAAABBBB);
        check_word("illegal_mem2", 2, 32'hBEEF7807);
    endtask

    task automatic test_reset_mid_rmw();
        int resp_seen;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h00000055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if ({req_ready, resp_valid, resp_rdata, resp_err, dmem_memRead, dmem_memWrite,
             dmem_addr, dmem_wdata} !== 100'h0) begin
            fails++; $display("FAIL midreset_outputs: write=%b ready=%b nonzero", dmem_memWrite, req_ready);
        end
        @(negedge clk);
        check_word("midreset_mem0", 0, 32'hAAAABBBB);
        rst_n = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL midreset_ready: got %b expected 1", req_ready);
        end
        resp_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        tests++;
        if (resp_seen != 0) begin
            fails++; $display("FAIL midreset_resp: got %0d responses expected 0", resp_seen);
        end
    endtask

    task automatic test_back_to_back();
        int   w0, r0, nresp;
        exp_t e;
        acc_q.delete();
        w0 = wr_cnt; r0 = rd_cnt; nresp = 0;
        sb_q.push_back('{32'h0, 1'b0, 2});
        sb_q.push_back('{32'h0, 1'b0, 2});
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'hC; req_wdata = 32'h11111111;
        @(posedge clk);
        #1 req_wdata = 32'h22222222;
        for (int i = 0; i < 20 && nresp < 2; i++) begin
            @(negedge clk);
            if (acc_q.size() >= 2) req_valid = 1'b0;
            if (resp_valid) begin
                nresp++;
                e = sb_q.pop_front();
                tests++;
                if (resp_err !== e.err || resp_rdata !== e.rdata) begin
                    fails++; $display("FAIL b2b_resp%0d: err=%b rdata=%h expected %b/%h",
                                      nresp, resp_err, resp_rdata, e.err, e.rdata);
                end
            end
        end
        req_valid = 1'b0;
        tests++;
        if (nresp != 2) begin
            fails++; $display("FAIL b2b_resp_count: got %0d expected 2", nresp);
            sb_q.delete();
        end
        tests++;
        if (acc_q.size() != 2) begin
            fails++; $display("FAIL b2b_accepts: got %0d expected 2", acc_q.size());
        end else begin
            tests++;
            if (acc_q[1] - acc_q[0] != 3) begin
                fails++; $display("FAIL b2b_accept_gap: got %0d expected 3", acc_q[1] - acc_q[0]);
            end
        end
        tests++;
        if (wr_cnt - w0 != 2 || rd_cnt != r0) begin
            fails++; $display("FAIL b2b_strobes: writes=%0d reads=%0d expected 2/0", wr_cnt - w0, rd_cnt - r0);
        end
        check_word("b2b_mem3", 3, 32'h22222222);
    endtask

    initial begin
        test_reset();
        test_word();
        test_load_extend();
        test_rmw();
        test_illegal();
        test_reset_mid_rmw();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
